ppm_frame_sync: RTL
===================

PPM_FRAME_SYNC -- requirements
Module: ppm_frame_sync

Interface
REQ-001 Parameter OSR, default 16: clk16 cycles per PPM slot.
REQ-002 Parameter FILT_LEN, default 2: consecutive equal samples needed to change the filtered level.
REQ-003 Parameter PULSE_MIN, default 2: minimum valid pulse width in cycles.
REQ-004 Parameter PULSE_MAX, default 12: maximum valid pulse width in cycles.
REQ-005 Parameter TOL, default 2: allowed +/- cycle error on the SOF interval.
REQ-006 Parameter SOF_SLOTS_4, default 4: SOF pulse-to-pulse interval in slots in 1-of-4 mode.
REQ-007 Parameter SOF_SLOTS_256, default 6: SOF pulse-to-pulse interval in slots in 1-of-256 mode.
REQ-008 Parameter EOF_SLOTS, default 12: idle-high slots that end a frame.
REQ-009 Parameter CW, default 12: interval counter width.
REQ-010 clk16  input  1  single clock; all logic on its rising edge.
REQ-011 rst_n  input  1  reset, synchronous, active-low.
REQ-012 Din  input  1  asynchronous PPM line; idle high, pulses low.
REQ-013 mode_256  input  1  0 = 1-of-4 SOF timing, 1 = 1-of-256 SOF timing.
REQ-014 sof_rcv_out  output  1  one-cycle pulse when a valid SOF is received.
REQ-015 eof_rcv_out  output  1  one-cycle pulse at end of frame.
REQ-016 in_frame  output  1  high from the SOF pulse until EOF or error.
REQ-017 pulse_strobe  output  1  one-cycle pulse per valid in-frame data pulse.
REQ-018 interval_out  output  CW  falling-edge-to-falling-edge interval in cycles, valid with pulse_strobe.
REQ-019 err_out  output  1  one-cycle pulse on an in-frame pulse-width violation.

Function
REQ-020 Din SHALL pass through a 2-flop synchroniser and then a FILT_LEN-sample majority-free filter, which changes level only after FILT_LEN equal consecutive samples; a Din edge therefore appears filtered 2+FILT_LEN cycles later (4 with defaults).
REQ-021 Low glitches shorter than FILT_LEN cycles SHALL be removed silently, with no error.
REQ-022 Pulse width SHALL be the number of cycles the filtered level is low; a pulse is valid iff PULSE_MIN <= width <= PULSE_MAX.
REQ-023 The interval counter SHALL restart at each filtered falling edge and saturate at 2^CW-1.
REQ-024 FSM states: IDLE, PULSE1, GAP, PULSE2, FRAME.
REQ-025 IDLE: latch mode_256 and go to PULSE1 on a filtered falling edge; mode_256 changes outside IDLE are ignored.
REQ-026 PULSE1: on the rising edge, go to GAP if the width is valid, else to IDLE; a width exceeding PULSE_MAX while still low SHALL abort to IDLE immediately.
REQ-027 GAP: on a falling edge with interval within SOF_SLOTS_x*OSR +/- TOL, go to PULSE2; on a falling edge with any other interval, stay in PULSE1 treating this edge as a new first pulse; on interval > SOF_SLOTS_x*OSR+TOL, go to IDLE.
REQ-028 PULSE2: a valid width SHALL assert sof_rcv_out on the cycle after the filtered rising edge, set in_frame, and go to FRAME; an invalid width goes to IDLE with no outputs.
REQ-029 FRAME, valid pulse: pulse_strobe and interval_out SHALL be registered on the cycle after the rising edge, with interval_out equal to the interval that ended at this pulse's falling edge.
REQ-030 FRAME, invalid pulse: err_out SHALL pulse, in_frame SHALL clear in the same cycle, and the FSM goes to IDLE.
REQ-031 FRAME, high for EOF_SLOTS*OSR cycles since the last falling edge: eof_rcv_out SHALL pulse, in_frame SHALL clear in the same cycle, and the FSM goes to IDLE.
REQ-032 sof_rcv_out, eof_rcv_out, pulse_strobe and err_out SHALL be mutually exclusive in any cycle.

Reset
REQ-033 With rst_n low at a clock edge, the FSM SHALL go to IDLE, all counters to 0, synchroniser and filter to 1, and every output to 0; this applies mid-frame as well.

Structure
REQ-034 Package ppm_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-035 Sub-module ppm_glitch_filter (synchroniser plus filter) SHALL be instantiated once.

Verification
REQ-036 Defaults, mode_256=0: Din low for cycles 0-3, low for 64-67 -> sof_rcv_out high at cycle 73, in_frame high from 73.
REQ-037 In frame: pulse of 4 cycles starting 40 cycles after the previous pulse -> pulse_strobe with interval_out=40; a pulse of 14 cycles -> err_out and in_frame=0.
REQ-038 SOF second pulse at interval 70 (1-of-4) -> no sof; the same timing repeated from that pulse with interval 64 -> sof.
REQ-039 Frame, then Din high for 192 cycles -> eof_rcv_out pulse exactly once, in_frame=0.
REQ-040 1-cycle low glitch in IDLE and in FRAME -> no output activity; rst_n low mid-frame -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ppm_pkg.sv
// PPM frame synchroniser: shared FSM state type and default parameters.
package ppm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE1,
        S_GAP,
        S_PULSE2,
        S_FRAME
    } state_e;

    localparam int OSR_D           = 16;
    localparam int FILT_LEN_D      = 2;
    localparam int PULSE_MIN_D     = 2;
    localparam int PULSE_MAX_D     = 12;
    localparam int TOL_D           = 2;
    localparam int SOF_SLOTS_4_D   = 4;
    localparam int SOF_SLOTS_256_D = 6;
    localparam int EOF_SLOTS_D     = 12;
    localparam int CW_D            = 12;

endpackage

// File: rtl/ppm_glitch_filter.sv
// Two-flop synchroniser followed by a FILT_LEN-sample level filter.
module ppm_glitch_filter
    import ppm_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_D
) (
    input  logic clk16,
    input  logic rst_n,
    input  logic din_i,
    output logic lvl_o
);

    logic                s1_q;
    logic                s2_q;
    logic [FILT_LEN-1:0] hist_q;
    logic                lvl_q;
    logic                lvl_d;

    // Level only moves when the whole history window agrees.
    always_comb begin
        lvl_d = lvl_q;
        if (&hist_q) begin
            lvl_d = 1'b1;
        end else if (~|hist_q) begin
            lvl_d = 1'b0;
        end
    end

    always_ff @(posedge clk16) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            hist_q <= '1;
            lvl_q  <= 1'b1;
        end else begin
            s1_q   <= din_i;
            s2_q   <= s1_q;
            hist_q <= (hist_q << 1) | FILT_LEN'(s2_q);
            lvl_q  <= lvl_d;
        end
    end

    assign lvl_o = lvl_q;

endmodule

// File: rtl/ppm_frame_sync.sv
// PPM receiver: SOF pair detection, in-frame pulse measurement and EOF.
module ppm_frame_sync
    import ppm_pkg::*;
#(
    parameter int OSR           = OSR_D,
    parameter int FILT_LEN      = FILT_LEN_D,
    parameter int PULSE_MIN     = PULSE_MIN_D,
    parameter int PULSE_MAX     = PULSE_MAX_D,
    parameter int TOL           = TOL_D,
    parameter int SOF_SLOTS_4   = SOF_SLOTS_4_D,
    parameter int SOF_SLOTS_256 = SOF_SLOTS_256_D,
    parameter int EOF_SLOTS     = EOF_SLOTS_D,
    parameter int CW            = CW_D
) (
    input  logic          clk16,
    input  logic          rst_n,
    input  logic          Din,
    input  logic          mode_256,
    output logic          sof_rcv_out,
    output logic          eof_rcv_out,
    output logic          in_frame,
    output logic          pulse_strobe,
    output logic [CW-1:0] interval_out,
    output logic          err_out
);

    localparam logic [CW-1:0] LO4   = CW'(SOF_SLOTS_4 * OSR - TOL);
    localparam logic [CW-1:0] HI4   = CW'(SOF_SLOTS_4 * OSR + TOL);
    localparam logic [CW-1:0] LO256 = CW'(SOF_SLOTS_256 * OSR - TOL);
    localparam logic [CW-1:0] HI256 = CW'(SOF_SLOTS_256 * OSR + TOL);
    localparam logic [CW-1:0] PMIN  = CW'(PULSE_MIN);
    localparam logic [CW-1:0] PMAX  = CW'(PULSE_MAX);
    localparam logic [CW-1:0] EOFC  = CW'(EOF_SLOTS * OSR);

    state_e        state_q, state_d;
    logic          lvl;
    logic          prev_q;
    logic [CW-1:0] ivl_q, ivl_d;
    logic [CW-1:0] wid_q, wid_d;
    logic [CW-1:0] ilat_q, ilat_d;
    logic          mode_q, mode_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic          stb_q, stb_d;
    logic          err_q, err_d;
    logic          inf_q, inf_d;
    logic [CW-1:0] iout_q, iout_d;

    logic          fall;
    logic          rise;
    logic          wid_ok;
    logic          over;
    logic [CW-1:0] lo;
    logic [CW-1:0] hi;

    ppm_glitch_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk16 (clk16),
        .rst_n (rst_n),
        .din_i (Din),
        .lvl_o (lvl)
    );

    assign fall   = prev_q & ~lvl;
    assign rise   = ~prev_q & lvl;
    assign wid_ok = (wid_q >= PMIN) && (wid_q <= PMAX);
    // wid_q is stale on the falling-edge cycle itself.
    assign over   = ~lvl && !fall && (wid_q >= PMAX);
    assign lo     = mode_q ? LO256 : LO4;
    assign hi     = mode_q ? HI256 : HI4;

    always_comb begin
        ivl_d  = ivl_q;
        wid_d  = wid_q;
        ilat_d = ilat_q;
        if (fall) begin
            ivl_d  = CW'(1);
            wid_d  = CW'(1);
            ilat_d = ivl_q;
        end else begin
            if (ivl_q != '1) ivl_d = ivl_q + CW'(1);
            if (!lvl && wid_q != '1) wid_d = wid_q + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        inf_d   = inf_q;
        iout_d  = iout_q;
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    mode_d  = mode_256;
                    state_d = S_PULSE1;
                end
            end
            S_PULSE1: begin
                if (rise) begin
                    state_d = wid_ok ? S_GAP : S_IDLE;
                end else if (over) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (fall) begin
                    if (ivl_q >= lo && ivl_q <= hi) state_d = S_PULSE2;
                    else                            state_d = S_PULSE1;
                end else if (ivl_q > hi) begin
                    state_d = S_IDLE;
                end
            end
            S_PULSE2: begin
                if (rise) begin
                    if (wid_ok) begin
                        sof_d   = 1'b1;
                        inf_d   = 1'b1;
                        state_d = S_FRAME;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (over) begin
                    state_d = S_IDLE;
                end
            end
            S_FRAME: begin
                if (rise && wid_ok) begin
                    stb_d  = 1'b1;
                    iout_d = ilat_q;
                end else if (rise || over) begin
                    err_d   = 1'b1;
                    inf_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (lvl && ivl_q >= EOFC) begin
                    eof_d   = 1'b1;
                    inf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk16) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prev_q  <= 1'b1;
            ivl_q   <= '0;
            wid_q   <= '0;
            ilat_q  <= '0;
            mode_q  <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            inf_q   <= 1'b0;
            iout_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= lvl;
            ivl_q   <= ivl_d;
            wid_q   <= wid_d;
            ilat_q  <= ilat_d;
            mode_q  <= mode_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            inf_q   <= inf_d;
            iout_q  <= iout_d;
        end
    end

    assign sof_rcv_out  = sof_q;
    assign eof_rcv_out  = eof_q;
    assign pulse_strobe = stb_q;
    assign err_out      = err_q;
    assign in_frame     = inf_q;
    assign interval_out = iout_q;

endmodule
